// File: rtl/posit_pkg.sv
// Shared definitions for the posit packing datapath: default widths,
// special-value patterns, the stage-1 payload record and the rounding-mode
// type. Widths of the payload record follow POSIT_N, so a different posit
// width is selected by changing the constants here.
package posit_pkg;

  localparam int POSIT_N  = 8;
  localparam int POSIT_ES = 3;

  // Only round-to-nearest-even exists today; the encoding leaves room for more.
  typedef enum logic [1:0] {
    RND_RNE = 2'd0
  } round_mode_e;

  // Everything stage 2 needs to round and pack one result.
  typedef struct packed {
    logic               sign;
    logic               nar;
    logic               zero;
    logic               sat_hi;
    logic               sat_lo;
    logic [POSIT_N-2:0] kept;
    logic               guard;
    logic               sticky;
  } s1_payload_t;

  // Largest positive posit: 0 followed by all ones.
  function automatic logic [POSIT_N-1:0] posit_maxpos();
    return {1'b0, {(POSIT_N-1){1'b1}}};
  endfunction

  // Smallest positive posit: all zeros except the lsb.
  function automatic logic [POSIT_N-1:0] posit_minpos();
    return {{(POSIT_N-1){1'b0}}, 1'b1};
  endfunction

  // Not-a-Real: 1 followed by all zeros.
  function automatic logic [POSIT_N-1:0] posit_nar();
    return {1'b1, {(POSIT_N-1){1'b0}}};
  endfunction

endpackage

// File: rtl/posit_pack_round_if.sv
// Handshake bundle for the posit packing stage: decoded result in,
// encoded posit out, each side with its own valid/ready pair.
interface posit_pack_round_if #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N),
  parameter int FW = N
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic                 in_zero;
  logic                 in_nar;
  logic signed [RS:0]   in_regime;
  logic [ES-1:0]        in_exp;
  logic [FW-1:0]        in_frac;
  logic                 in_sticky;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_posit;

  // Producer of decoded results / consumer of posits.
  modport master (
    output in_valid, in_sign, in_zero, in_nar, in_regime, in_exp, in_frac,
           in_sticky, out_ready,
    input  in_ready, out_valid, out_posit
  );

  // The packing stage itself.
  modport slave (
    input  in_valid, in_sign, in_zero, in_nar, in_regime, in_exp, in_frac,
           in_sticky, out_ready,
    output in_ready, out_valid, out_posit
  );

endinterface

// File: rtl/posit_regime_gen.sv
// Combinational regime generator: turns a signed regime value k into the
// left-aligned regime run (k>=0: k+1 ones then 0, k<0: -k zeros then 1),
// its length including the terminator, and the saturation flags.
// k is widened by one bit before negation so the most negative k is safe.
module posit_regime_gen #(
  parameter int N  = 8,
  parameter int RS = $clog2(N)
) (
  input  logic signed [RS:0]   k,
  output logic [N-1:0]         regime_str,
  output logic [RS+1:0]        regime_len,
  output logic                 sat_hi,
  output logic                 sat_lo
);

  localparam int KW = RS + 2;
  localparam logic signed [KW-1:0] K_HI = KW'(N - 2);
  localparam logic signed [KW-1:0] K_LO = KW'(-(N - 1));

  logic signed [KW-1:0] k_ext;
  logic                 k_neg;
  logic [KW-1:0]        k_mag;
  logic [KW-1:0]        run;

  assign k_ext = {k[RS], k};
  assign k_neg = k_ext[KW-1];
  assign k_mag = k_neg ? $unsigned(-k_ext) : $unsigned(k_ext);

  // Number of identical leading bits before the terminating bit.
  assign run        = k_neg ? k_mag : k_mag + 1'b1;
  assign regime_len = run + 1'b1;

  // Bit at position gi (counted from the msb): run bits, terminator, then zeros.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_regime_bit
      localparam logic [KW-1:0] POS = KW'(gi);
      assign regime_str[N-1-gi] = (POS < run) ? !k_neg :
                                  (POS == run) ? k_neg : 1'b0;
    end
  endgenerate

  assign sat_hi = (k_ext >= K_HI);
  assign sat_lo = (k_ext <= K_LO);

endmodule

// File: rtl/posit_pack_round.sv
// Two-stage elastic posit encoder. Stage 1 builds the regime/exponent/
// fraction body and splits it into kept bits, guard and sticky; stage 2
// rounds to nearest even, clamps to maxpos/minpos, applies the zero/NaR
// specials and negates for negative results.
// Optional build macro POSIT_PACK_STATS_EN adds saturating 16-bit counters
// of rounded-up and clamped posits leaving the block.
module posit_pack_round
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N),
  parameter int FW = N
) (
  input  logic               clk,
  input  logic               reset,
`ifdef POSIT_PACK_STATS_EN
  output logic [15:0]        stat_round_up,
  output logic [15:0]        stat_saturate,
`endif
  posit_pack_round_if.slave  bus
);

  // Body field: widest unsaturated regime plus exponent and fraction, so
  // nothing is lost before the sticky reduction.
  localparam int FIELD_W = N + ES + FW;
  localparam round_mode_e RMODE = RND_RNE;
  localparam logic [N-1:0] MAXPOS = posit_maxpos();
  localparam logic [N-1:0] MINPOS = posit_minpos();
  localparam logic [N-1:0] NAR    = posit_nar();

  // ---------------- handshake ----------------
  logic s1_valid_reg;
  logic out_valid_reg;
  logic s2_load;
  logic s1_load;

  assign s2_load      = !out_valid_reg || bus.out_ready;
  assign s1_load      = !s1_valid_reg || s2_load;
  assign bus.in_ready = s1_load;
  assign bus.out_valid = out_valid_reg;

  // ---------------- stage 1: build ----------------
  logic [N-1:0]       regime_str;
  logic [RS+1:0]      regime_len;
  logic               sat_hi_c;
  logic               sat_lo_c;
  logic [FIELD_W-1:0] field_src;
  logic [FIELD_W-1:0] field;
  s1_payload_t        s1_next;
  s1_payload_t        s1_reg;

  posit_regime_gen #(.N(N), .RS(RS)) u_regime (
    .k          (bus.in_regime),
    .regime_str (regime_str),
    .regime_len (regime_len),
    .sat_hi     (sat_hi_c),
    .sat_lo     (sat_lo_c)
  );

  // Exponent and fraction follow directly after the regime terminator.
  assign field_src = {bus.in_exp, bus.in_frac, {N{1'b0}}};
  assign field     = (field_src >> regime_len) | {regime_str, {(ES+FW){1'b0}}};

  // Split the body into the N-1 kept bits, guard bit and sticky.
  always_comb begin
    s1_next        = '0;
    s1_next.sign   = bus.in_sign;
    s1_next.nar    = bus.in_nar;
    s1_next.zero   = bus.in_zero;
    s1_next.sat_hi = sat_hi_c;
    s1_next.sat_lo = sat_lo_c;
    s1_next.kept   = field[FIELD_W-1 -: N-1];
    s1_next.guard  = field[FIELD_W-N];
    s1_next.sticky = (|field[FIELD_W-N-1:0]) | bus.in_sticky;
  end

  // Stage 1 register: accepts a new result whenever it is empty or draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_reg <= s1_next;
      end
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic         rnd_inc;
  logic [N-1:0] sum;
  logic         carry;
  logic [N-1:0] mag;
  logic [N-1:0] posit_next;
  logic [N-1:0] out_posit_reg;

  // Round the kept bits, clamp, then apply specials and sign.
  always_comb begin
    rnd_inc    = 1'b0;
    mag        = '0;
    posit_next = '0;
    case (RMODE)
      RND_RNE: rnd_inc = s1_reg.guard && (s1_reg.sticky || s1_reg.kept[0]);
      default: rnd_inc = s1_reg.guard && (s1_reg.sticky || s1_reg.kept[0]);
    endcase
    sum   = {1'b0, s1_reg.kept} + {{(N-1){1'b0}}, rnd_inc};
    carry = sum[N-1];
    if (s1_reg.sat_hi) begin
      mag = MAXPOS;
    end else if (s1_reg.sat_lo) begin
      mag = MINPOS;
    end else if (carry) begin
      mag = MAXPOS;
    end else begin
      mag = sum;
    end
    if (s1_reg.nar) begin
      posit_next = NAR;
    end else if (s1_reg.zero) begin
      posit_next = '0;
    end else begin
      posit_next = s1_reg.sign ? -mag : mag;
    end
  end

  // Output register: holds its payload while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_posit_reg <= '0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_posit_reg <= posit_next;
      end
    end
  end

  assign bus.out_posit = out_posit_reg;

`ifdef POSIT_PACK_STATS_EN
  logic         normal_c;
  logic         round_up_next;
  logic         clamp_next;
  logic         round_up_reg;
  logic         clamp_reg;
  logic [15:0]  round_up_cnt_reg;
  logic [15:0]  saturate_cnt_reg;

  // Classify the posit being packed: plain round-up versus clamped.
  always_comb begin
    normal_c      = !s1_reg.nar && !s1_reg.zero;
    round_up_next = normal_c && !s1_reg.sat_hi && !s1_reg.sat_lo && rnd_inc && !carry;
    clamp_next    = normal_c && (s1_reg.sat_hi || s1_reg.sat_lo || carry);
  end

  // Flags travel alongside the output payload; counters saturate at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      round_up_reg     <= 1'b0;
      clamp_reg        <= 1'b0;
      round_up_cnt_reg <= '0;
      saturate_cnt_reg <= '0;
    end else begin
      if (s2_load && s1_valid_reg) begin
        round_up_reg <= round_up_next;
        clamp_reg    <= clamp_next;
      end
      if (out_valid_reg && bus.out_ready) begin
        if (round_up_reg && (round_up_cnt_reg != 16'hFFFF)) begin
          round_up_cnt_reg <= round_up_cnt_reg + 16'd1;
        end
        if (clamp_reg && (saturate_cnt_reg != 16'hFFFF)) begin
          saturate_cnt_reg <= saturate_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign stat_round_up = round_up_cnt_reg;
  assign stat_saturate = saturate_cnt_reg;
`endif

endmodule

// File: tb/tb_posit_pack_round.sv
// Scoreboard bench for posit_pack_round (N=8, ES=3): the driver pushes the
// hand-computed posit for every accepted input, a monitor pops and compares
// on every output handshake. Covers encoding, rounding, saturation, specials,
// back-pressure and mid-stream reset.
module tb_posit_pack_round;

  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = 3;
  localparam int FW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  posit_pack_round_if #(.N(N), .ES(ES), .RS(RS), .FW(FW)) bus ();

`ifdef POSIT_PACK_STATS_EN
  logic [15:0] stat_round_up;
  logic [15:0] stat_saturate;
`endif

  posit_pack_round #(.N(N), .ES(ES), .RS(RS), .FW(FW)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef POSIT_PACK_STATS_EN
    .stat_round_up (stat_round_up),
    .stat_saturate (stat_saturate),
`endif
    .bus           (bus)
  );

  typedef struct {
    logic              sgn;
    logic              zro;
    logic              nar;
    logic signed [3:0] k;
    logic [2:0]        e;
    logic [7:0]        f;
    logic              st;
    logic [7:0]        expv;
    string             name;
  } vec_t;

  typedef struct {
    logic [7:0] expv;
    int         acc_cyc;
    bit         lat;
    string      name;
  } sb_t;

  sb_t  sb_q[$];
  vec_t p1[$];
  vec_t bp[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic sgn, input logic zro, input logic nar,
                              input int k, input int e, input int f, input logic st,
                              input int expv, input string name);
    vec_t v;
    v.sgn  = sgn;
    v.zro  = zro;
    v.nar  = nar;
    v.k    = 4'(k);
    v.e    = 3'(e);
    v.f    = 8'(f);
    v.st   = st;
    v.expv = 8'(expv);
    v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Present one input and wait (bounded) for it to be accepted.
  task automatic send(input vec_t v, input bit lat);
    int waited = 0;
    bit got = 0;
    sb_t e;
    bus.in_sign   = v.sgn;
    bus.in_zero   = v.zro;
    bus.in_nar    = v.nar;
    bus.in_regime = v.k;
    bus.in_exp    = v.e;
    bus.in_frac   = v.f;
    bus.in_sticky = v.st;
    bus.in_valid  = 1'b1;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got       = 1;
        e.expv    = v.expv;
        e.acc_cyc = cyc;
        e.lat     = lat;
        e.name    = v.name;
        sb_q.push_back(e);
        acc_cnt++;
      end else begin
        waited++;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s accept timeout: in_ready=0 required=1", v.name);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Pop the expected posit on every output handshake and compare.
  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %02h required none", bus.out_posit);
        end else begin
          e = sb_q.pop_front();
          total++;
          if (bus.out_posit !== e.expv) begin
            bad++;
            $display("FAIL %s: out_posit=%02h required=%02h", e.name, bus.out_posit, e.expv);
          end else begin
            $display("ok   %s: out_posit=%02h", e.name, bus.out_posit);
          end
          if (e.lat) begin
            total++;
            if (cyc - e.acc_cyc != 2) begin
              bad++;
              $display("FAIL %s latency: got %0d required 2", e.name, cyc - e.acc_cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s drain: pending=%0d required 0", name, sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_zero   = 1'b0;
    bus.in_nar    = 1'b0;
    bus.in_regime = '0;
    bus.in_exp    = '0;
    bus.in_frac   = '0;
    bus.in_sticky = 1'b0;
    bus.out_ready = 1'b1;

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_posit", 32'(bus.out_posit), 32'h00);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed encodings, no stall: every result must appear 2 cycles later
    p1.push_back(mk(0, 0, 0,  0, 0, 8'h00, 0, 8'h40, "k0"));
    p1.push_back(mk(1, 0, 0,  0, 0, 8'h00, 0, 8'hC0, "k0_neg"));
    p1.push_back(mk(0, 0, 0, -1, 5, 8'h00, 0, 8'h34, "km1_e5"));
    p1.push_back(mk(1, 0, 0, -1, 5, 8'h00, 0, 8'hCC, "km1_e5_neg"));
    p1.push_back(mk(1, 0, 1,  3, 2, 8'h55, 1, 8'h80, "nar"));
    p1.push_back(mk(1, 1, 0,  2, 1, 8'hF0, 0, 8'h00, "zero_neg"));
    p1.push_back(mk(0, 1, 1,  0, 0, 8'h00, 0, 8'h80, "nar_over_zero"));
    p1.push_back(mk(0, 0, 0,  0, 0, 8'hA0, 0, 8'h42, "tie_even"));
    p1.push_back(mk(0, 0, 0,  0, 0, 8'hE0, 0, 8'h44, "tie_odd"));
    p1.push_back(mk(0, 0, 0,  0, 0, 8'hA0, 1, 8'h43, "above_half"));
    p1.push_back(mk(0, 0, 0,  0, 0, 8'h90, 0, 8'h42, "below_half"));
    p1.push_back(mk(0, 0, 0, -6, 7, 8'h00, 0, 8'h02, "km6_round"));
    p1.push_back(mk(0, 0, 0,  5, 0, 8'h00, 0, 8'h7E, "k5"));
    p1.push_back(mk(0, 0, 0,  6, 0, 8'h00, 0, 8'h7F, "k6_sat"));
    p1.push_back(mk(0, 0, 0,  7, 0, 8'h00, 0, 8'h7F, "k7_sat"));
    p1.push_back(mk(0, 0, 0, -7, 0, 8'h00, 0, 8'h01, "km7_sat"));
    p1.push_back(mk(0, 0, 0, -8, 0, 8'h00, 0, 8'h01, "km8_sat"));
    p1.push_back(mk(0, 0, 0,  5, 7, 8'hFF, 1, 8'h7F, "k5_carry"));
    p1.push_back(mk(1, 0, 0, -8, 0, 8'h00, 0, 8'hFF, "km8_neg"));
    p1.push_back(mk(1, 0, 0,  7, 3, 8'h00, 0, 8'h81, "k7_neg"));
    foreach (p1[i]) send(p1[i], 1'b1);
    drain("directed");

    // Back-pressure: 4 back-to-back inputs against a stalled consumer
    bp.push_back(mk(0, 0, 0,  1, 0, 8'h00, 0, 8'h60, "bp_k1"));
    bp.push_back(mk(0, 0, 0,  2, 0, 8'h00, 0, 8'h70, "bp_k2"));
    bp.push_back(mk(0, 0, 0, -2, 0, 8'h00, 0, 8'h10, "bp_km2"));
    bp.push_back(mk(0, 0, 0, -3, 0, 8'h00, 0, 8'h08, "bp_km3"));
    acc_cnt = 0;
    out_cnt = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        foreach (bp[i]) send(bp[i], 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_accepted_2", 32'(acc_cnt), 32'd2);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_0", 32'(bus.out_posit), 32'h60);
        @(negedge clk);
        chk("bp_hold_1", 32'(bus.out_posit), 32'h60);
        @(negedge clk);
        chk("bp_hold_2", 32'(bus.out_posit), 32'h60);
        chk("bp_in_ready_still_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("backpressure");
    chk("bp_count", 32'(out_cnt), 32'd4);

    // Reset with both stages occupied
    bus.out_ready = 1'b0;
    send(mk(0, 0, 0, 1, 1, 8'h00, 0, 8'h62, "rst_a"), 1'b0);
    send(mk(0, 0, 0, 2, 1, 8'h00, 0, 8'h71, "rst_b"), 1'b0);
    chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_reset_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_posit", 32'(bus.out_posit), 32'h00);
`ifdef POSIT_PACK_STATS_EN
    chk("midrst_stat_round_up", 32'(stat_round_up), 32'd0);
    chk("midrst_stat_saturate", 32'(stat_saturate), 32'd0);
`endif
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(mk(0, 0, 0, 0, 1, 8'h00, 0, 8'h44, "post_reset_k0_e1"), 1'b1);
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
